// File: rtl/plusarg_watchdog_pkg.sv
// Shared types for the plusarg-driven run watchdog: controller states and failure codes.
package plusarg_watchdog_pkg;

  typedef enum logic [1:0] {
    StSettle = 2'd0,
    StRun    = 2'd1,
    StPass   = 2'd2,
    StFail   = 2'd3
  } wd_state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_TOTAL = 2'b01;
  localparam logic [1:0] FC_STALL = 2'b10;
  localparam logic [1:0] FC_BOTH  = 2'b11;

endpackage

// File: rtl/plusarg_watchdog_ctrl_counter.sv
// Saturating up-counter with synchronous clear and a flag that goes high when the
// post-update value equals a non-zero limit.
module wd_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // A limit of zero means "disabled"; a clear cycle can never be a hit.
  assign hit_o   = en_i && !clr_i && (limit_i != '0) && (count_d == limit_i);

endmodule

// File: rtl/plusarg_watchdog_ctrl.sv
// Run controller: waits out a settle window, latches the plusarg limits, then watches
// total run length and progress stalls, ending in a sticky PASS or FAIL.
module plusarg_watchdog_ctrl
  import plusarg_watchdog_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned PROG_W        = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cfg_max_cycles,
  input  logic [CNT_W-1:0]  cfg_stall_cycles,
  input  logic [PROG_W-1:0] progress,
  input  logic              done,
  output logic              running,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  wd_state_e        state_q;
  logic [SW-1:0]    settle_q;
  logic [CNT_W-1:0] lim_total_q, lim_stall_q;
  logic [CNT_W-1:0] stall_count;
  logic             run_en, any_prog, total_hit, stall_hit;

  assign run_en   = (state_q == StRun);
  assign any_prog = |progress;

  wd_sat_counter #(.CNT_W(CNT_W)) u_total_cnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (1'b0),
    .en_i    (run_en),
    .limit_i (lim_total_q),
    .count_o (cycle_count),
    .hit_o   (total_hit)
  );

  wd_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (run_en && any_prog),
    .en_i    (run_en),
    .limit_i (lim_stall_q),
    .count_o (stall_count),
    .hit_o   (stall_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StSettle;
      settle_q    <= '0;
      lim_total_q <= '0;
      lim_stall_q <= '0;
      running     <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= FC_NONE;
    end else begin
      unique case (state_q)
        StSettle: begin
          // Limits are sampled once, after plusarg_reader values have resolved.
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            lim_total_q <= cfg_max_cycles;
            lim_stall_q <= cfg_stall_cycles;
            running     <= 1'b1;
            state_q     <= StRun;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        StRun: begin
          if (done) begin
            running <= 1'b0;
            pass    <= 1'b1;
            state_q <= StPass;
          end else if (total_hit || stall_hit) begin
            running   <= 1'b0;
            fail      <= 1'b1;
            fail_code <= total_hit ? (stall_hit ? FC_BOTH : FC_TOTAL) : FC_STALL;
            state_q   <= StFail;
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_stall;
  assign unused_stall = ^stall_count;

endmodule

// File: tb/tb_plusarg_watchdog_ctrl.sv
// Bench for plusarg_watchdog_ctrl: table of run scenarios with a result scoreboard,
// plus hand sequences for mid-run cfg changes, async reset and counter saturation.
module tb_plusarg_watchdog_ctrl;

  typedef struct {
    logic [31:0] mx;
    logic [31:0] st;
    logic [31:0] mask;
    int          done_cyc;
    bit          done_settle;
    bit          e_pass;
    bit          e_fail;
    logic [1:0]  e_code;
    int          e_cnt;
  } vec_t;

  typedef struct {
    bit         e_pass;
    bit         e_fail;
    logic [1:0] e_code;
    int         e_cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cfg_max = '0, cfg_stall = '0;
  logic        progress = 1'b0, done = 1'b0;
  logic        running, pass, fail;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count;

  logic [3:0]  cfg4 = '0;
  logic        progress4 = 1'b0, done4 = 1'b0;
  logic        running4, pass4, fail4;
  logic [1:0]  fail_code4;
  logic [3:0]  cycle_count4;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  always #5 clock = ~clock;

  plusarg_watchdog_ctrl #(.CNT_W(32), .SETTLE_CYCLES(4), .PROG_W(1)) dut (
    .clock            (clock),
    .reset            (reset),
    .cfg_max_cycles   (cfg_max),
    .cfg_stall_cycles (cfg_stall),
    .progress         (progress),
    .done             (done),
    .running          (running),
    .pass             (pass),
    .fail             (fail),
    .fail_code        (fail_code),
    .cycle_count      (cycle_count)
  );

  plusarg_watchdog_ctrl #(.CNT_W(4), .SETTLE_CYCLES(4), .PROG_W(1)) dut4 (
    .clock            (clock),
    .reset            (reset),
    .cfg_max_cycles   (cfg4),
    .cfg_stall_cycles (cfg4),
    .progress         (progress4),
    .done             (done4),
    .running          (running4),
    .pass             (pass4),
    .fail             (fail4),
    .fail_code        (fail_code4),
    .cycle_count      (cycle_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called just after an active edge; leaves the bench #1 after the RUN-entry edge.
  task automatic reset_settle(input logic [31:0] mx, input logic [31:0] st, input logic d);
    cfg_max   = mx;
    cfg_stall = st;
    progress  = 1'b0;
    done      = d;
    reset     = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("settle_running_low", running, 0);
    chk("settle_no_pass", pass, 0);
    @(posedge clock);
    #1;
    chk("run_entry_running", running, 1);
  endtask

  task automatic run_case(input vec_t v, input string tag);
    exp_t e;
    int   term_edge;
    sb_q.push_back('{v.e_pass, v.e_fail, v.e_code, v.e_cnt});
    reset_settle(v.mx, v.st, v.done_settle);
    term_edge = 0;
    for (int k = 1; k <= 40; k++) begin
      progress = (k <= 32) ? v.mask[k-1] : 1'b0;
      done     = v.done_settle || (k == v.done_cyc);
      @(posedge clock);
      #1;
      if (pass || fail) begin
        term_edge = k;
        break;
      end
    end
    progress = 1'b0;
    done     = 1'b0;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pass"}, pass, e.e_pass);
      chk({tag, "_fail"}, fail, e.e_fail);
      chk({tag, "_code"}, fail_code, e.e_code);
      chk({tag, "_count"}, cycle_count, e.e_cnt);
      chk({tag, "_edge"}, term_edge, e.e_cnt);
      chk({tag, "_running"}, running, 0);
      repeat (3) @(posedge clock);
      #1;
      chk({tag, "_frozen_count"}, cycle_count, e.e_cnt);
      chk({tag, "_held_flags"}, {pass, fail}, {e.e_pass, e.e_fail});
    end
  endtask

  initial begin
    //          max  stall mask          done dset pass fail code  cnt
    vecs[0] = '{32'd10, 32'd0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b1, 2'b01, 10};
    vecs[1] = '{32'd0,  32'd5, 32'h0000_0005, 0, 1'b0, 1'b0, 1'b1, 2'b10, 8};
    vecs[2] = '{32'd6,  32'd0, 32'hFFFF_FFFF, 6, 1'b0, 1'b1, 1'b0, 2'b00, 6};
    vecs[3] = '{32'd7,  32'd7, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b1, 2'b11, 7};
    vecs[4] = '{32'd3,  32'd0, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 1'b0, 2'b00, 1};
    vecs[5] = '{32'd0,  32'd2, 32'h0000_0015, 0, 1'b0, 1'b0, 1'b1, 2'b10, 7};
    vecs[6] = '{32'd3,  32'd0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b1, 2'b01, 3};

    #2;
    chk("reset_running", running, 0);
    chk("reset_pass", pass, 0);
    chk("reset_fail", fail, 0);
    chk("reset_code", fail_code, 0);
    chk("reset_count", cycle_count, 0);
    @(posedge clock);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_case(vecs[i], $sformatf("vec%0d", i));
    end

    // Limit changed mid-run must be ignored; async reset then re-latches the new value.
    reset_settle(32'd100, 32'd0, 1'b0);
    progress = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    cfg_max = 32'd3;
    repeat (3) @(posedge clock);
    #1;
    chk("cfg_change_no_fail", fail, 0);
    chk("cfg_change_count", cycle_count, 5);
    chk("cfg_change_running", running, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_running", running, 0);
    chk("async_rst_count", cycle_count, 0);
    chk("async_rst_fail", fail, 0);
    @(posedge clock);
    #1;
    run_case(vecs[6], "relatch");

    // Unlimited run on the 4-bit instance: counter must stick at all-ones.
    reset_settle(32'd0, 32'd0, 1'b0);
    progress = 1'b1;
    repeat (14) @(posedge clock);
    #1;
    chk("sat4_count_14", cycle_count4, 14);
    repeat (26) @(posedge clock);
    #1;
    chk("sat4_count_sat", cycle_count4, 15);
    chk("sat4_running", running4, 1);
    chk("sat4_pass", pass4, 0);
    chk("sat4_fail", fail4, 0);
    chk("sat32_count", cycle_count, 40);
    chk("sat32_running", running, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
